// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage for a single-cycle RISC-V core. Holds the PC, owns
// the on-chip instruction memory, and presents the instruction at PC to the
// decoders every cycle. A program is first streamed in through a valid/ready
// loader port; execution then runs until a fault (or, optionally, an ecall).
//
// Optional feature macro:
//   IFU_HALT_ON_ECALL_EN - when defined, an unstalled ecall (32'h0000_0073)
//                          in RUN halts the unit cleanly (fault stays 0).
//
// Parameters:
//   IMEM_DEPTH  instruction memory size in 32-bit words (power of two, 4..1024)
//   RESET_PC    PC on reset and on entry to RUN (word aligned, inside memory)
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   load_valid   loader presents load_data
//   load_data    program word
//   load_ready   unit accepts a word this cycle
//   load_done    loader finished, start execution
//   stall        hold the PC for this cycle (PCSrc ignored)
//   PCSrc        branch taken
//   ImmExt       sign-extended branch offset
//   PC           current instruction address
//   PCPlus4      PC + 4
//   Instr        instruction at PC, NOP when instr_valid = 0
//   instr_valid  Instr is a real fetched instruction
//   halted       unit is in HALT
//   fault        sticky: halt caused by a misaligned / out-of-range PC
//   state_dbg    current FSM state (0 = LOAD, 1 = RUN, 2 = HALT)
//
// Loader handshake: a word is transferred on a rising edge where both
// load_valid and load_ready are high. load_ready never depends on load_valid;
// the loader may hold load_valid high and stream one word per cycle.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    input  logic        load_done,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] ImmExt,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  state_dbg
);

    localparam int          AW      = $clog2(IMEM_DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(IMEM_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] ECALL   = 32'h0000_0073;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state;
    logic [AW:0] wr_ptr;      // next write address; equals DEPTH when full
    logic [AW:0] prog_len;    // words loaded, latched on load_done
    logic [31:0] pc;
    logic        fault_q;

    // Not reset: program contents survive rst by design.
    logic [31:0] imem [IMEM_DEPTH];

    logic        transfer;
    logic [AW:0] len_next;
    logic [31:0] rd_word;
    logic [31:0] pc_seq;
    logic [31:0] pc_cand;
    logic        cand_bad;
    logic        is_ecall;

    assign load_ready = (state == S_LOAD) && (wr_ptr < DEPTH_W);
    assign transfer   = load_valid && load_ready;

    // A word accepted in the same cycle as load_done counts toward prog_len.
    assign len_next = wr_ptr + (AW + 1)'(transfer);

    // Asynchronous read: fetch latency is zero.
    assign rd_word = imem[pc[AW+1:2]];

    assign pc_seq  = pc + 32'd4;
    assign pc_cand = PCSrc ? (pc + ImmExt) : pc_seq;

    // Word index compared against the loaded length; a negative wrap lands on
    // a huge index and is caught by the same test.
    assign cand_bad = (pc_cand[1:0] != 2'b00) || (pc_cand[31:2] >= 30'(prog_len));

`ifdef IFU_HALT_ON_ECALL_EN
    assign is_ecall = (rd_word == ECALL);
`else
    assign is_ecall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (transfer) begin
            imem[wr_ptr[AW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_LOAD;
            wr_ptr   <= '0;
            prog_len <= '0;
            pc       <= RESET_PC;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (transfer) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    if (load_done) begin
                        prog_len <= len_next;
                        pc       <= RESET_PC;
                        if (len_next == '0) begin
                            state   <= S_HALT;
                            fault_q <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (is_ecall) begin
                            state <= S_HALT;
                        end else if (cand_bad) begin
                            // PC keeps the last good address.
                            state   <= S_HALT;
                            fault_q <= 1'b1;
                        end else begin
                            pc <= pc_cand;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

    assign PC          = pc;
    assign PCPlus4     = pc_seq;
    assign instr_valid = (state == S_RUN);
    assign Instr       = (state == S_RUN) ? rd_word : NOP;
    assign halted      = (state == S_HALT);
    assign fault       = fault_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 64;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid, load_done, stall, PCSrc;
  logic [31:0] load_data, ImmExt;
  logic        load_ready, instr_valid, halted, fault;
  logic [31:0] PC, PCPlus4, Instr;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  instr_fetch_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .stall(stall), .PCSrc(PCSrc), .ImmExt(ImmExt),
    .PC(PC), .PCPlus4(PCPlus4), .Instr(Instr), .instr_valid(instr_valid),
    .halted(halted), .fault(fault), .state_dbg(state_dbg)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit check_en = 1'b0;
  logic [31:0] prog [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = loading, 1 = running, 2 = halted
  int          m_mode;
  int unsigned m_wr, m_len;
  logic [31:0] m_pc;
  bit          m_fault;
  logic [31:0] m_mem [DEPTH];

  function automatic int unsigned accepted(input logic v, input int unsigned wr);
    return (v && wr < DEPTH) ? 1 : 0;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] p, input logic br,
                                          input logic [31:0] imm);
    return br ? p + imm : p + 32'd4;
  endfunction

  function automatic bit pc_ok(input logic [31:0] p, input int unsigned len);
    return (p % 4 == 0) && ((p / 4) < len);
  endfunction

  function automatic bit ecall_halts(input logic [31:0] ins);
`ifdef IFU_HALT_ON_ECALL_EN
    return ins == 32'h0000_0073;
`else
    return (ins != ins);
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  <= 0;
      m_wr    <= 0;
      m_len   <= 0;
      m_pc    <= RESET_PC;
      m_fault <= 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (accepted(load_valid, m_wr) == 1) begin
            m_mem[m_wr] <= load_data;
            m_wr        <= m_wr + 1;
          end
          if (load_done) begin
            m_len   <= m_wr + accepted(load_valid, m_wr);
            m_pc    <= RESET_PC;
            m_mode  <= (m_wr + accepted(load_valid, m_wr) == 0) ? 2 : 1;
            m_fault <= (m_wr + accepted(load_valid, m_wr) == 0);
          end
        end
        1: begin
          if (!stall) begin
            if (ecall_halts(m_mem[m_pc / 4])) begin
              m_mode <= 2;
            end else if (!pc_ok(next_pc(m_pc, PCSrc, ImmExt), m_len)) begin
              m_mode  <= 2;
              m_fault <= 1'b1;
            end else begin
              m_pc <= next_pc(m_pc, PCSrc, ImmExt);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_pc", PC, m_pc);
      chk("m_pcplus4", PCPlus4, m_pc + 32'd4);
      chk("m_instr", Instr, (m_mode == 1) ? m_mem[m_pc / 4] : NOP);
      chk("m_instr_valid", {31'd0, instr_valid}, {31'd0, m_mode == 1});
      chk("m_halted", {31'd0, halted}, {31'd0, m_mode == 2});
      chk("m_fault", {31'd0, fault}, {31'd0, m_fault});
      chk("m_load_ready", {31'd0, load_ready}, {31'd0, (m_mode == 0) && (m_wr < DEPTH)});
      chk("m_state", {30'd0, state_dbg}, m_mode);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    load_valid = 1'b0;
    load_data  = '0;
    load_done  = 1'b0;
    stall      = 1'b0;
    PCSrc      = 1'b0;
    ImmExt     = '0;
  endtask

  // Asserts rst between edges and checks reset values before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_pc", PC, RESET_PC);
    chk("rst_pcplus4", PCPlus4, RESET_PC + 32'd4);
    chk("rst_instr", Instr, NOP);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_prog(input int n, input bit done_with_last);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      load_done  = done_with_last && (i == n - 1);
      chk("load_ready_beat", {31'd0, load_ready}, 32'd1);
      step(1);
    end
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  task automatic finish_load();
    load_done = 1'b1;
    step(1);
    load_done = 1'b0;
  endtask

  task automatic chk_halt(input string name, input logic [31:0] pc_exp, input bit f_exp);
    chk({name, "_halted"}, {31'd0, halted}, 32'd1);
    chk({name, "_fault"}, {31'd0, fault}, {31'd0, f_exp});
    chk({name, "_pc"}, PC, pc_exp);
    chk({name, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({name, "_nop"}, Instr, NOP);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_en = 1'b1;

    // 4-word program, sequential run, fault past the end
    do_reset();
    prog[0] = 32'h0050_0093; prog[1] = 32'h0010_8113;
    prog[2] = 32'h0020_81b3; prog[3] = 32'h0031_8233;
    load_prog(4, 1'b0);
    finish_load();
    chk("t1_pc0", PC, 32'd0);  chk("t1_i0", Instr, 32'h0050_0093);
    chk("t1_valid", {31'd0, instr_valid}, 32'd1);
    step(1); chk("t1_pc4", PC, 32'd4);   chk("t1_i1", Instr, 32'h0010_8113);
    step(1); chk("t1_pc8", PC, 32'd8);   chk("t1_i2", Instr, 32'h0020_81b3);
    step(1); chk("t1_pc12", PC, 32'd12); chk("t1_i3", Instr, 32'h0031_8233);
    step(1); chk_halt("t1", 32'd12, 1'b1);

    // Fill all 64 words, a 65th offered word is refused
    do_reset();
    for (int i = 0; i < DEPTH; i++) prog[i] = 32'hA000_0000 + i;
    for (int i = 0; i <= DEPTH; i++) begin
      load_valid = 1'b1;
      load_data  = (i < DEPTH) ? prog[i] : 32'hDEAD_BEEF;
      chk("t2_ready", {31'd0, load_ready}, (i < DEPTH) ? 32'd1 : 32'd0);
      step(1);
    end
    load_valid = 1'b0;
    finish_load();
    chk("t2_i0", Instr, 32'hA000_0000);
    step(63);
    chk("t2_pc_last", PC, 32'd252); chk("t2_i_last", Instr, 32'hA000_003F);
    step(1); chk_halt("t2", 32'd252, 1'b1);

    // Backward branch, then misaligned branch target
    do_reset();
    for (int i = 0; i < 8; i++) prog[i] = 32'h1100_0000 + (i << 8);
    load_prog(8, 1'b0);
    finish_load();
    step(2); chk("t3_pc8", PC, 32'd8);
    PCSrc = 1'b1; ImmExt = 32'hFFFF_FFF8;
    step(1); PCSrc = 1'b0;
    chk("t3_br_pc", PC, 32'd0); chk("t3_br_i", Instr, 32'h1100_0000);
    step(2); chk("t3_pc8b", PC, 32'd8);
    PCSrc = 1'b1; ImmExt = 32'd6;
    step(1); PCSrc = 1'b0; ImmExt = '0;
    chk_halt("t3", 32'd8, 1'b1);

    // Stall holds PC for 3 cycles despite PCSrc
    do_reset();
    load_prog(8, 1'b0);
    finish_load();
    step(1);
    stall = 1'b1; PCSrc = 1'b1; ImmExt = 32'd8;
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_pc", PC, 32'd4);
      chk("t4_stall_i", Instr, 32'h1100_0100);
      step(1);
    end
    stall = 1'b0; PCSrc = 1'b0; ImmExt = '0;
    chk("t4_held_pc", PC, 32'd4);
    step(1); chk("t4_pc8", PC, 32'd8);
    step(1); chk("t4_pc12", PC, 32'd12); chk("t4_i3", Instr, 32'h1100_0300);

    // ecall at word 2
    do_reset();
    prog[0] = 32'h0050_0093; prog[1] = 32'h0010_8113;
    prog[2] = 32'h0000_0073; prog[3] = 32'h0031_8233;
    load_prog(4, 1'b0);
    finish_load();
    chk("t5_pc0", PC, 32'd0);
    step(2); chk("t5_pc8", PC, 32'd8); chk("t5_ecall", Instr, 32'h0000_0073);
    chk("t5_ecall_valid", {31'd0, instr_valid}, 32'd1);
    step(1);
`ifdef IFU_HALT_ON_ECALL_EN
    chk_halt("t5_ecall_halt", 32'd8, 1'b0);
`else
    chk("t5_pc12", PC, 32'd12); chk("t5_i3", Instr, 32'h0031_8233);
    step(1); chk_halt("t5_end", 32'd12, 1'b1);
`endif

    // Async reset mid-RUN, then word + load_done in the same cycle,
    // then a branch that wraps below address 0
    do_reset();
    for (int i = 0; i < 8; i++) prog[i] = 32'h2200_0000 + i;
    load_prog(8, 1'b0);
    finish_load();
    step(2); chk("t6_pc8", PC, 32'd8);
    do_reset();
    prog[0] = 32'h0FF0_0093;
    load_prog(1, 1'b1);
    chk("t6_pc0", PC, 32'd0); chk("t6_i0", Instr, 32'h0FF0_0093);
    chk("t6_valid", {31'd0, instr_valid}, 32'd1);
    PCSrc = 1'b1; ImmExt = 32'hFFFF_FFFC;
    step(1); PCSrc = 1'b0; ImmExt = '0;
    chk_halt("t6_wrap", 32'd0, 1'b1);

    // load_done with nothing loaded, then HALT ignores the loader
    do_reset();
    finish_load();
    chk_halt("t7_empty", RESET_PC, 1'b1);
    load_valid = 1'b1; load_data = 32'h1234_5678;
    chk("t7_ready", {31'd0, load_ready}, 32'd0);
    step(2);
    load_valid = 1'b0;
    chk_halt("t7_after", RESET_PC, 1'b1);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Safety net: the directed sequence is bounded, but never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
